// File: rtl/ntt_butterfly_cfg.sv
// Pipelined radix-2 NTT/INTT butterfly (CT forward / GS inverse per beat) with a self-generated twiddle index.
// Optional build macro NTT_BFLY_HALVE_EN: GS outputs are scaled by 2^-1 mod Q in the last stage.
module ntt_butterfly_cfg #(
  parameter int             W         = 28,
  parameter logic [W-1:0]   Q         = W'(268369921),
  parameter int             MULT_LAT  = 5,
  parameter int             N_TW      = 64,
  parameter int             START     = 6,
  parameter int             TW_STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    sync,
  input  logic                    mode,
  input  logic [W-1:0]            x_in,
  input  logic [W-1:0]            y_in,
  output logic [$clog2(N_TW)-1:0] tw_idx,
  input  logic [W-1:0]            tw_in,
  output logic                    out_valid,
  output logic [W-1:0]            x_out,
  output logic [W-1:0]            y_out
);

  localparam int IW = $clog2(N_TW);
  localparam int BW = $clog2(START + 2);
  localparam int L  = MULT_LAT - 1;
  localparam logic [BW-1:0] START_C  = BW'(START);
  localparam logic [IW-1:0] STRIDE_C = IW'(TW_STRIDE);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, Q}) ? W'(s - {1'b0, Q}) : W'(s);
  endfunction

  // W-bit wraparound makes a-b+Q exact whenever a < b.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? (a - b) : (a - b + Q);
  endfunction

`ifdef NTT_BFLY_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    logic [W:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, Q}) : {1'b0, v};
    return t[W:1];
  endfunction
`endif

  // Twiddle index generation; a sync beat is evaluated from a zero baseline.
  logic [BW-1:0] bc, bc_base, bc_next;
  logic [IW-1:0] idx, idx_base, idx_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bc_base  = (in_valid && sync) ? '0 : bc;
    idx_base = (in_valid && sync) ? '0 : idx;
    tw_idx   = (bc_base < START_C) ? '0 : idx_base;
    bc_next  = bc;
    idx_next = idx;
    if (in_valid) begin
      if (bc_base < START_C) begin
        bc_next  = bc_base + BW'(1);
        idx_next = idx_base;
      end else begin
        bc_next  = bc_base;
        idx_next = idx_base + STRIDE_C;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc  <= '0;
      idx <= '0;
    end else begin
      bc  <= bc_next;
      idx <= idx_next;
    end
  end

  // Stage 1: GS pre-add/sub, CT pass-through; twiddle captured alongside.
  logic         s1_valid, s1_gs;
  logic [W-1:0] s1_a, s1_b, s1_w;

  // NOTE: datapath registers carry no reset; only the valid bits need one, and data is consumed only when valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_gs <= mode;
      s1_w  <= tw_in;
      if (mode) begin
        s1_a <= mod_add(x_in, y_in);
        s1_b <= mod_sub(x_in, y_in);
      end else begin
        s1_a <= x_in;
        s1_b <= y_in;
      end
    end
  end

  // Modular multiplier: reduction feeds the first register, the rest are retiming stages.
  logic [W-1:0]        m_pipe [MULT_LAT];
  logic [W-1:0]        a_pipe [MULT_LAT];
  logic [MULT_LAT-1:0] v_pipe, g_pipe;

  always_ff @(posedge clk) begin
    m_pipe[0] <= W'(({{W{1'b0}}, s1_b} * {{W{1'b0}}, s1_w}) % {{W{1'b0}}, Q});
    a_pipe[0] <= s1_a;
    g_pipe[0] <= s1_gs;
    for (int k = 1; k < MULT_LAT; k++) begin
      m_pipe[k] <= m_pipe[k-1];
      a_pipe[k] <= a_pipe[k-1];
      g_pipe[k] <= g_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      v_pipe   <= '0;
    end else begin
      s1_valid  <= in_valid;
      v_pipe[0] <= s1_valid;
      for (int k = 1; k < MULT_LAT; k++) v_pipe[k] <= v_pipe[k-1];
    end
  end

  logic [W-1:0] x_nxt, y_nxt;

  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (g_pipe[L]) begin
`ifdef NTT_BFLY_HALVE_EN
      x_nxt = halve(a_pipe[L]);
      y_nxt = halve(m_pipe[L]);
`else
      x_nxt = a_pipe[L];
      y_nxt = m_pipe[L];
`endif
    end else begin
      x_nxt = mod_add(a_pipe[L], m_pipe[L]);
      y_nxt = mod_sub(a_pipe[L], m_pipe[L]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= v_pipe[L];
      if (v_pipe[L]) begin
        x_out <= x_nxt;
        y_out <= y_nxt;
      end
    end
  end

endmodule
